// File: rtl/controller_nios_0_cpu_debug_pkg.sv
// Shared constants for the Nios OCI debug memory block: FSM encoding,
// jdo field positions and the default write-protect limit.
package controller_nios_0_cpu_debug_pkg;

  // FSM state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // jdo field positions
  localparam int unsigned JDO_ADDR_HI = 24;
  localparam int unsigned JDO_ADDR_LO = 17;
  localparam int unsigned JDO_DATA_HI = 34;
  localparam int unsigned JDO_DATA_LO = 3;
  localparam int unsigned JDO_RD_BIT  = 35;
  localparam int unsigned JDO_CLR_BIT = 36;

  // Words 0..PROTECT_TOP_DEFAULT are read-only from the debug side
  localparam int unsigned PROTECT_TOP_DEFAULT = 32'h3F;

endpackage

// File: rtl/controller_nios_0_cpu_debug_ocimem_if.sv
// Debug-slave bus between the JTAG debug module (master) and the OCI
// memory block (slave): command word, strobes and monitor status.
interface controller_nios_0_cpu_debug_ocimem_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic              busy;

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  MonDReg, MonAReg, monitor_ready, monitor_error, busy
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output MonDReg, MonAReg, monitor_ready, monitor_error, busy
  );
endinterface

// File: rtl/controller_nios_0_cpu_ociram_sp.sv
// Single-port OCI RAM, 2^ADDR_W x 32, registered read data (1-clock latency).
// Contents are intentionally not reset.
module controller_nios_0_cpu_ociram_sp #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wrdata,
  input  logic              wren,
  output logic [31:0]       q
);
  logic [31:0] mem [2**ADDR_W];

  // Synchronous write and registered read-before-write
  always_ff @(posedge clk) begin
    if (wren) mem[address] <= wrdata;
    q <= mem[address];
  end
endmodule

// File: rtl/controller_nios_0_cpu_debug_ocimem.sv
// OCI debug memory controller: decodes debug-slave strobes into address
// loads, RAM reads and protected RAM writes, with monitor status flags.
module controller_nios_0_cpu_debug_ocimem
  import controller_nios_0_cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned PROTECT_TOP = PROTECT_TOP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] PROT_LIM = ADDR_W'(PROTECT_TOP);

  logic [1:0]        state_q, state_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              op_wr_q, op_wr_d;
  logic              op_inc_q, op_inc_d;

  logic              any_strobe, multi_strobe;
  logic              err_set, err_clr;
  logic [31:0]       ram_q;
  logic              ram_we;

  logic [7:0]        jdo_addr;
  logic [31:0]       jdo_data;
  logic              unused_jdo_bits;

  assign jdo_addr        = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
  assign jdo_data        = jdo[JDO_DATA_HI:JDO_DATA_LO];
  assign unused_jdo_bits = ^{jdo[37], jdo[2:0]};

  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b)
                      | (take_action_ocimem_a & take_no_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a);

  // Next-state decode: strobe priority b > a > no_action_a, busy strobes flagged
  always_comb begin
    state_d  = state_q;
    mon_d_d  = mon_d_q;
    mon_a_d  = mon_a_q;
    ready_d  = ready_q;
    op_wr_d  = op_wr_q;
    op_inc_d = op_inc_q;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_strobe) begin
          ready_d = 1'b0;
          if (multi_strobe) err_set = 1'b1;
          if (take_action_ocimem_b) begin
            mon_d_d = jdo_data;
            op_wr_d = 1'b1;
            state_d = ST_ACCESS;
            if (mon_a_q <= PROT_LIM) err_set = 1'b1;
          end else if (take_action_ocimem_a) begin
            mon_a_d = ADDR_W'(jdo_addr);
            err_clr = jdo[JDO_CLR_BIT];
            if (jdo[JDO_RD_BIT]) begin
              op_wr_d  = 1'b0;
              op_inc_d = 1'b0;
              state_d  = ST_ACCESS;
            end else begin
              ready_d = 1'b1;
            end
          end else begin
            op_wr_d  = 1'b0;
            op_inc_d = 1'b1;
            state_d  = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (any_strobe) err_set = 1'b1;
        if (op_wr_q) begin
          mon_a_d = mon_a_q + 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (any_strobe) err_set = 1'b1;
        mon_d_d = ram_q;
        if (op_inc_q) mon_a_d = mon_a_q + 1'b1;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // a new error wins over a clear on the same edge
    error_d = (error_q & ~err_clr) | err_set;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mon_d_q  <= '0;
      mon_a_q  <= '0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      op_wr_q  <= 1'b0;
      op_inc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mon_d_q  <= mon_d_d;
      mon_a_q  <= mon_a_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      op_wr_q  <= op_wr_d;
      op_inc_q <= op_inc_d;
    end
  end

  // Write enable comes straight from registered state, so reset kills it at once
  assign ram_we = (state_q == ST_ACCESS) && op_wr_q && (mon_a_q > PROT_LIM);

  controller_nios_0_cpu_ociram_sp #(.ADDR_W(ADDR_W)) u_ociram (
    .clk     (clk),
    .address (mon_a_q),
    .wrdata  (mon_d_q),
    .wren    (ram_we),
    .q       (ram_q)
  );

  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_controller_nios_0_cpu_debug_ocimem.sv
// Directed bench for the OCI debug memory controller.
module tb_controller_nios_0_cpu_debug_ocimem;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edges;
  logic [31:0] snap10;

  always #5 clk = ~clk;

  controller_nios_0_cpu_debug_ocimem_if #(.ADDR_W(8)) bus ();

  controller_nios_0_cpu_debug_ocimem #(.ADDR_W(8), .PROTECT_TOP(32'h3F)) dut (
    .clk                     (clk),
    .reset_n                 (rst_n),
    .jdo                     (bus.jdo),
    .take_action_ocimem_a    (bus.take_action_ocimem_a),
    .take_action_ocimem_b    (bus.take_action_ocimem_b),
    .take_no_action_ocimem_a (bus.take_no_action_ocimem_a),
    .MonDReg                 (bus.MonDReg),
    .MonAReg                 (bus.MonAReg),
    .monitor_ready           (bus.monitor_ready),
    .monitor_error           (bus.monitor_error),
    .busy                    (bus.busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j = '0;
    j[36] = clr;
    j[35] = rd;
    j[24:17] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Present strobes for exactly one rising edge; return at edge + 1
  task automatic strobe(input logic a, input logic b, input logic na, input logic [37:0] j);
    @(negedge clk);
    bus.jdo = j;
    bus.take_action_ocimem_a = a;
    bus.take_action_ocimem_b = b;
    bus.take_no_action_ocimem_a = na;
    @(posedge clk);
    #1;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
  endtask

  // Count edges from the sampling edge (edge 1) until ready is seen, bounded
  task automatic wait_ready(output int n);
    n = 1;
    while (!bus.monitor_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.monitor_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    #1;
    check_eq("rst_mond", bus.MonDReg, 32'h0);
    check_eq("rst_mona", 32'(bus.MonAReg), 32'h0);
    check_eq("rst_ready", 32'(bus.monitor_ready), 32'd0);
    check_eq("rst_error", 32'(bus.monitor_error), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Address load then write
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'h40));
    wait_ready(edges);
    check_eq("aload_lat", 32'(edges), 32'd1);
    check_eq("aload_mona", 32'(bus.MonAReg), 32'h40);
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'hDEADBEEF));
    check_eq("wr_ready_clr", 32'(bus.monitor_ready), 32'd0);
    check_eq("wr_busy", 32'(bus.busy), 32'd1);
    wait_ready(edges);
    check_eq("wr_lat", 32'(edges), 32'd2);
    check_eq("wr_mona", 32'(bus.MonAReg), 32'h41);
    check_eq("wr_mond", bus.MonDReg, 32'hDEADBEEF);
    check_eq("wr_err", 32'(bus.monitor_error), 32'd0);

    // Address load with read
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h40));
    wait_ready(edges);
    check_eq("rd_lat", 32'(edges), 32'd3);
    check_eq("rd_mond", bus.MonDReg, 32'hDEADBEEF);
    check_eq("rd_mona", 32'(bus.MonAReg), 32'h40);

    // Known value at 0x50 for the reset test
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'h50));
    wait_ready(edges);
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'hA5A50050));
    wait_ready(edges);
    check_eq("wr50_mona", 32'(bus.MonAReg), 32'h51);

    // Read-next wraps the address
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'hFF));
    wait_ready(edges);
    strobe(1'b0, 1'b0, 1'b1, '0);
    wait_ready(edges);
    check_eq("rdn_lat", 32'(edges), 32'd3);
    check_eq("wrap_mona", 32'(bus.MonAReg), 32'h00);
    check_eq("wrap_err", 32'(bus.monitor_error), 32'd0);

    // Protected write
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h10));
    wait_ready(edges);
    snap10 = bus.MonDReg;
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'h10));
    wait_ready(edges);
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
    wait_ready(edges);
    check_eq("prot_lat", 32'(edges), 32'd2);
    check_eq("prot_mona", 32'(bus.MonAReg), 32'h11);
    check_eq("prot_mond", bus.MonDReg, 32'h12345678);
    check_eq("prot_err", 32'(bus.monitor_error), 32'd1);
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h10));
    wait_ready(edges);
    check_eq("prot_ram10", bus.MonDReg, snap10);
    check_eq("prot_err_sticky", 32'(bus.monitor_error), 32'd1);
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h10));
    wait_ready(edges);
    check_eq("err_clear", 32'(bus.monitor_error), 32'd0);

    // Strobe while busy is ignored
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'h40));
    wait_ready(edges);
    strobe(1'b0, 1'b0, 1'b1, '0);
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h55556666));
    wait_ready(edges);
    check_eq("busy_mond", bus.MonDReg, 32'hDEADBEEF);
    check_eq("busy_mona", 32'(bus.MonAReg), 32'h41);
    check_eq("busy_err", 32'(bus.monitor_error), 32'd1);
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h70));
    wait_ready(edges);
    check_eq("busy_err_clr", 32'(bus.monitor_error), 32'd0);

    // Simultaneous a+b: only the write runs
    strobe(1'b1, 1'b1, 1'b0, jdo_b(32'h33334444));
    wait_ready(edges);
    check_eq("multi_lat", 32'(edges), 32'd2);
    check_eq("multi_mona", 32'(bus.MonAReg), 32'h71);
    check_eq("multi_err", 32'(bus.monitor_error), 32'd1);
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h70));
    wait_ready(edges);
    check_eq("multi_ram70", bus.MonDReg, 32'h33334444);

    // Reset during write ACCESS
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'h50));
    wait_ready(edges);
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h9999AAAA));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_mond", bus.MonDReg, 32'h0);
    check_eq("mid_rst_mona", 32'(bus.MonAReg), 32'h0);
    check_eq("mid_rst_ready", 32'(bus.monitor_ready), 32'd0);
    check_eq("mid_rst_err", 32'(bus.monitor_error), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h50));
    wait_ready(edges);
    check_eq("rst_ram50", bus.MonDReg, 32'hA5A50050);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
